// File: rtl/shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg: serial-in, parallel-out bidirectional shift register    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module shift_reg #(
    parameter int MSB = 8
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           en_i,
    input  logic           dir_i,
    input  logic           data_i,
    output logic [MSB-1:0] data_o
);

    logic [MSB-1:0] data_q;
    logic [MSB-1:0] data_d;

    // A one-bit register has no neighbours to shift, so both directions load.
    generate
        if (MSB == 1) begin : g_single
            always_comb begin
                data_d = data_q;
                if (en_i) begin
                    data_d = data_i;
                end
            end
        end else begin : g_multi
            always_comb begin
                data_d = data_q;
                if (en_i) begin
                    if (dir_i) begin
                        data_d = {data_i, data_q[MSB-1:1]};
                    end else begin
                        data_d = {data_q[MSB-2:0], data_i};
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_reg: scoreboard bench for shift_reg (MSB=8 and MSB=1)     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_shift_reg;

    logic       clk_i;
    logic       rstn_i;
    logic       en_i;
    logic       dir_i;
    logic       data_i;
    logic [7:0] data8_o;
    logic [0:0] data1_o;

    int n_checks;
    int n_pass;

    logic [7:0] m8;
    logic       m1;
    logic [7:0] exp8_q[$];
    logic       exp1_q[$];

    shift_reg #(.MSB(8)) u_dut8 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .dir_i  (dir_i),
        .data_i (data_i),
        .data_o (data8_o)
    );

    shift_reg #(.MSB(1)) u_dut1 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .dir_i  (dir_i),
        .data_i (data_i),
        .data_o (data1_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Called at a falling edge; drives one rising edge and scores both widths.
    task automatic step(input logic en, input logic dir, input logic din);
        en_i   = en;
        dir_i  = dir;
        data_i = din;
        if (!rstn_i) begin
            m8 = 8'h00;
            m1 = 1'b0;
        end else if (en) begin
            m8 = dir ? {din, m8[7:1]} : {m8[6:0], din};
            m1 = din;
        end
        exp8_q.push_back(m8);
        exp1_q.push_back(m1);
        @(posedge clk_i);
        #1;
        chk("sb8", data8_o, exp8_q.pop_front());
        chk("sb1", {7'b0, data1_o}, {7'b0, exp1_q.pop_front()});
        @(negedge clk_i);
    endtask

    initial begin
        logic [7:0] alt;
        logic [7:0] rfill;
        n_checks = 0;
        n_pass   = 0;
        m8       = 8'h00;
        m1       = 1'b0;
        rstn_i   = 1'b0;
        en_i     = 1'b0;
        dir_i    = 1'b0;
        data_i   = 1'b0;
        alt      = 8'b10101010;
        rfill    = 8'b11000000;

        #3;
        chk("reset8", data8_o, 8'h00);
        chk("reset1", {7'b0, data1_o}, 8'h00);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Left fill 1,0,1,0,...
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, alt[7-i]);
            if (i == 2) chk("left_e3", data8_o, 8'b00000101);
        end
        chk("left_full", data8_o, 8'b10101010);

        // Asynchronous reset between edges, then held low with en_i=1.
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("async_clr", data8_o, 8'h00);
        m8 = 8'h00;
        m1 = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b1);
        chk("rst_held", data8_o, 8'h00);
        rstn_i = 1'b1;

        // Right fill 1,1,0,0,...
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, rfill[7-i]);
            if (i == 0) chk("right_e1", data8_o, 8'b10000000);
        end
        chk("right_full", data8_o, 8'b00000011);

        // Reload, then hold with toggling inputs.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, alt[7-i]);
        chk("reload", data8_o, 8'b10101010);
        for (int i = 0; i < 5; i++) step(1'b0, i[0], ~i[0]);
        chk("hold", data8_o, 8'b10101010);

        // Direction switch on consecutive edges.
        step(1'b1, 1'b1, 1'b1);
        chk("dir_right", data8_o, 8'b11010101);
        step(1'b1, 1'b0, 1'b0);
        chk("dir_left", data8_o, 8'b10101010);

        // Single-bit width: load 1, then hold with data_i=0.
        step(1'b1, 1'b1, 1'b1);
        chk("w1_load", {7'b0, data1_o}, 8'h01);
        step(1'b0, 1'b0, 1'b0);
        chk("w1_hold", {7'b0, data1_o}, 8'h01);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
